freq_generator: RTL and testbench

FREQ_GENERATOR -- requirements
Module: freq_generator

---
 rtl/freq_generator_pkg.sv | 13 +
 rtl/freq_generator_seg7.sv | 24 ++
 rtl/freq_generator.sv | 84 ++++++++
 tb/tb_freq_generator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_generator_pkg.sv
// Shared constants and helpers for the digit-controlled square-wave generator.
package freq_generator_pkg;

  localparam int unsigned FRAME_LEN = 20;
  localparam int unsigned MAX_DIGIT = 9;
  localparam int unsigned ACC_W     = 5;
  localparam int unsigned DIGIT_W   = 4;

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(MAX_DIGIT)) ? DIGIT_W'(MAX_DIGIT) : d;
  endfunction

endpackage

// File: rtl/freq_generator_seg7.sv
// 7-segment decoder, segments {g,f,e,d,c,b,a}, active high; non-decimal codes blank.
module freq_generator_seg7 (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    unique case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = '0;
    endcase
  end

endmodule

// File: rtl/freq_generator.sv
// Fractional-rate toggle generator: (2*D+1) toggles of sig_o per 20-cycle frame.
module freq_generator
  import freq_generator_pkg::*;
#(
  parameter int unsigned INIT_DIGIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               load_i,
  input  logic               enable_i,
  output logic               sig_o,
  output logic [DIGIT_W-1:0] digit_o,
  output logic [6:0]         seg_o,
  output logic               frame_o
);

  localparam logic [DIGIT_W-1:0] INIT_Q   = DIGIT_W'(INIT_DIGIT);
  localparam logic [ACC_W:0]     FRAME_W  = (ACC_W+1)'(FRAME_LEN);
  localparam logic [ACC_W-1:0]   LAST_CNT = ACC_W'(FRAME_LEN - 1);

  logic [ACC_W-1:0]   acc, acc_d;
  logic [ACC_W-1:0]   frame_cnt, frame_cnt_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               sig_q, sig_d;
  logic               frame_q, frame_d;
  logic [ACC_W-1:0]   inc;
  logic [ACC_W:0]     sum;

  always_comb begin
    inc         = {digit_q, 1'b1};
    sum         = {1'b0, acc} + {1'b0, inc};
    acc_d       = acc;
    frame_cnt_d = frame_cnt;
    digit_d     = digit_q;
    sig_d       = sig_q;
    frame_d     = 1'b0;
    if (load_i) begin
      digit_d     = clamp_digit(digit_i);
      acc_d       = '0;
      frame_cnt_d = '0;
    end else if (enable_i) begin
      // Overflow past one frame's worth of phase emits a toggle.
      if (sum >= FRAME_W) begin
        acc_d = ACC_W'(sum - FRAME_W);
        sig_d = ~sig_q;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
      if (frame_cnt == LAST_CNT) begin
        frame_cnt_d = '0;
        frame_d     = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      frame_cnt <= '0;
      digit_q   <= INIT_Q;
      sig_q     <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      acc       <= acc_d;
      frame_cnt <= frame_cnt_d;
      digit_q   <= digit_d;
      sig_q     <= sig_d;
      frame_q   <= frame_d;
    end
  end

  assign sig_o   = sig_q;
  assign digit_o = digit_q;
  assign frame_o = frame_q;

  freq_generator_seg7 u_seg7 (
    .digit (digit_q),
    .seg   (seg_o)
  );

endmodule

// File: tb/tb_freq_generator.sv
// Scoreboarded bench for freq_generator: a toggle-count model predicts outputs per cycle.
module tb_freq_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_i;
  logic       load_i;
  logic       enable_i;
  logic       sig_o;
  logic [3:0] digit_o;
  logic [6:0] seg_o;
  logic       frame_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       sig;
    logic       frame;
    logic [3:0] digit;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];
  logic [6:0] seg_tab [0:9];

  // Model: toggles after n enabled cycles since load = floor(n*(2D+1)/20).
  int   m_digit;
  int   m_n;
  logic m_base;
  logic m_sig;
  logic m_frame;

  freq_generator #(.INIT_DIGIT(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .digit_i  (digit_i),
    .load_i   (load_i),
    .enable_i (enable_i),
    .sig_o    (sig_o),
    .digit_o  (digit_o),
    .seg_o    (seg_o),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({sig_o, frame_o, digit_o, seg_o} !== e) begin
        errors++;
        $display("FAIL sb_cycle t=%0t actual sig=%b frame=%b digit=%0d seg=%h required sig=%b frame=%b digit=%0d seg=%h",
                 $time, sig_o, frame_o, digit_o, seg_o, e.sig, e.frame, e.digit, e.seg);
      end
    end
  end

  task automatic model_reset();
    m_digit = 0;
    m_n     = 0;
    m_base  = 1'b0;
    m_sig   = 1'b0;
    m_frame = 1'b0;
  endtask

  // Drive one cycle, push the predicted post-edge outputs, return at negedge+1.
  task automatic drive(input logic ld, input int d, input logic en);
    exp_t e;
    load_i   = ld;
    digit_i  = 4'(d);
    enable_i = en;
    if (ld) begin
      m_digit = (d > 9) ? 9 : d;
      m_n     = 0;
      m_base  = m_sig;
      m_frame = 1'b0;
    end else if (en) begin
      m_n     = m_n + 1;
      m_frame = ((m_n % 20) == 0);
      m_sig   = m_base ^ 1'(((m_n * (2 * m_digit + 1)) / 20) & 1);
    end else begin
      m_frame = 1'b0;
    end
    e.sig   = m_sig;
    e.frame = m_frame;
    e.digit = 4'(m_digit);
    e.seg   = seg_tab[m_digit];
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Run n enabled cycles, counting sig_o changes and frame pulses.
  task automatic run(input int n, output int toggles, output int frames);
    logic prev;
    toggles = 0;
    frames  = 0;
    for (int i = 0; i < n; i++) begin
      prev = sig_o;
      drive(1'b0, 0, 1'b1);
      if (sig_o !== prev) toggles++;
      if (frame_o === 1'b1) frames++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    load_i   = 1'b0;
    enable_i = 1'b1;
    digit_i  = 4'd7;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({sig_o, frame_o, digit_o, seg_o} !== {1'b0, 1'b0, 4'd0, 7'h3F}) begin
      errors++;
      $display("FAIL reset_state actual sig=%b frame=%b digit=%0d seg=%h required 0 0 0 3f",
               sig_o, frame_o, digit_o, seg_o);
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_digit0();
    int t, f;
    drive(1'b1, 0, 1'b0);
    run(20, t, f);
    checks++;
    if (t != 1) begin errors++; $display("FAIL d0_toggles actual %0d required 1", t); end
    checks++;
    if (f != 1) begin errors++; $display("FAIL d0_frames actual %0d required 1", f); end
  endtask

  task automatic test_digit9();
    int t, f;
    logic s0;
    drive(1'b1, 9, 1'b0);
    s0 = sig_o;
    drive(1'b0, 0, 1'b1);
    checks++;
    if (sig_o !== s0) begin errors++; $display("FAIL d9_edge1 actual %b required %b", sig_o, s0); end
    drive(1'b0, 0, 1'b1);
    checks++;
    if (sig_o !== ~s0) begin errors++; $display("FAIL d9_edge2 actual %b required %b", sig_o, ~s0); end
    run(18, t, f);
    checks++;
    if (t != 18) begin errors++; $display("FAIL d9_toggles actual %0d required 18 after first", t); end
    checks++;
    if (digit_o !== 4'd9) begin errors++; $display("FAIL d9_digit actual %0d required 9", digit_o); end
  endtask

  task automatic test_clamp();
    int t, f;
    drive(1'b1, 12, 1'b0);
    checks++;
    if (digit_o !== 4'd9) begin errors++; $display("FAIL clamp_digit actual %0d required 9", digit_o); end
    checks++;
    if (seg_o !== 7'h6F) begin errors++; $display("FAIL clamp_seg actual %h required 6f", seg_o); end
    run(20, t, f);
    checks++;
    if (t != 19) begin errors++; $display("FAIL clamp_toggles actual %0d required 19", t); end
  endtask

  task automatic test_freeze();
    int t1, t2, f1, f2;
    logic held;
    drive(1'b1, 4, 1'b0);
    run(7, t1, f1);
    held = sig_o;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 0, 1'b0);
      checks++;
      if (sig_o !== held || frame_o !== 1'b0) begin
        errors++;
        $display("FAIL freeze_hold actual sig=%b frame=%b required sig=%b frame=0", sig_o, frame_o, held);
      end
    end
    run(13, t2, f2);
    checks++;
    if (t1 + t2 != 9) begin errors++; $display("FAIL freeze_toggles actual %0d required 9", t1 + t2); end
    checks++;
    if (f1 + f2 != 1) begin errors++; $display("FAIL freeze_frames actual %0d required 1", f1 + f2); end
  endtask

  task automatic test_reset_mid();
    int t, f;
    drive(1'b1, 5, 1'b0);
    run(12, t, f);
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (sig_o !== 1'b0 || frame_o !== 1'b0 || digit_o !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset actual sig=%b frame=%b digit=%0d required 0 0 0", sig_o, frame_o, digit_o);
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 5, 1'b0);
    run(20, t, f);
    checks++;
    if (t != 11) begin errors++; $display("FAIL mid_toggles actual %0d required 11", t); end
    checks++;
    if (f != 1) begin errors++; $display("FAIL mid_frames actual %0d required 1", f); end
  endtask

  task automatic test_sweep();
    int t, f;
    for (int d = 0; d < 10; d++) begin
      drive(1'b1, d, 1'b0);
      run(40, t, f);
      checks++;
      if (t != 2 * (2 * d + 1)) begin
        errors++;
        $display("FAIL sweep_d%0d actual %0d required %0d", d, t, 2 * (2 * d + 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive loads with enable high: load wins every cycle, nothing toggles.
    logic s0;
    s0 = sig_o;
    drive(1'b1, 3, 1'b1);
    drive(1'b1, 15, 1'b1);
    drive(1'b1, 2, 1'b1);
    checks++;
    if (sig_o !== s0 || digit_o !== 4'd2) begin
      errors++;
      $display("FAIL b2b_load actual sig=%b digit=%0d required sig=%b digit=2", sig_o, digit_o, s0);
    end
  endtask

  initial begin
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
    test_reset();
    test_digit0();
    test_digit9();
    test_clamp();
    test_freeze();
    test_reset_mid();
    test_sweep();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
